// File: rtl/shift_rotate_pipe_if.sv
// Valid/ready request and result bus of the shift/rotate/swap pipeline.
// The producer/consumer side uses master; the unit itself uses slave.
interface shift_rotate_pipe_if #(
  parameter int WIDTH = 20,
  parameter int AMT_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [AMT_W-1:0] in_amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res_a;
  logic [WIDTH-1:0] out_res_b;
  logic             out_err;

  modport master (
    output in_valid, in_op, in_a, in_b, in_amt, out_ready,
    input  in_ready, out_valid, out_res_a, out_res_b, out_err
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_amt, out_ready,
    output in_ready, out_valid, out_res_a, out_res_b, out_err
  );
endinterface

// File: rtl/shift_rotate_pipe.sv
// Two-stage shift/rotate/swap unit: S1 captures operands and the normalised
// amount, S2 computes and holds the result until the consumer takes it.
module shift_rotate_pipe #(
  parameter int WIDTH = 20,
  parameter int AMT_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  shift_rotate_pipe_if.slave bus,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int          ROT_W   = $clog2(WIDTH);
  localparam logic [31:0] WIDTH_U = 32'(WIDTH);

  typedef enum logic [2:0] {
    OP_SHR  = 3'b000,
    OP_SHL  = 3'b001,
    OP_ROR  = 3'b010,
    OP_ROL  = 3'b011,
    OP_ASR  = 3'b100,
    OP_SWAP = 3'b101
  } op_e;

  logic adv1, adv2;

  logic             s1_valid_q, s1_valid_d;
  logic [2:0]       s1_op_q,    s1_op_d;
  logic [WIDTH-1:0] s1_a_q,     s1_a_d;
  logic [WIDTH-1:0] s1_b_q,     s1_b_d;
  logic [ROT_W-1:0] s1_rot_q,   s1_rot_d;
  logic             s1_sat_q,   s1_sat_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] res_a_q,    res_a_d;
  logic [WIDTH-1:0] res_b_q,    res_b_d;
  logic             err_q,      err_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  logic [WIDTH-1:0] shr_v, shl_v, asr_v, ror_v, rol_v;
  logic [WIDTH-1:0] calc_a, calc_b;
  logic             calc_err;

  // in_ready is a function of state and out_ready only, never of in_*.
  assign adv2         = !s2_valid_q || bus.out_ready;
  assign adv1         = !s1_valid_q || adv2;
  assign bus.in_ready = adv1;

  always_comb begin
    // NOTE: every variable gets a hold default before any branch so no latch is inferred.
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_rot_d   = s1_rot_q;
    s1_sat_d   = s1_sat_q;
    if (adv1) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_op_d  = bus.in_op;
        s1_a_d   = bus.in_a;
        s1_b_d   = bus.in_b;
        s1_rot_d = ROT_W'(32'(bus.in_amt) % WIDTH_U);
        s1_sat_d = (32'(bus.in_amt) >= WIDTH_U);
      end
    end
  end

  // When not saturated the raw amount is below WIDTH, so it equals s1_rot_q.
  always_comb begin
    shr_v = s1_sat_q ? '0 : (s1_a_q >> s1_rot_q);
    shl_v = s1_sat_q ? '0 : (s1_a_q << s1_rot_q);
    asr_v = s1_sat_q ? {WIDTH{s1_a_q[WIDTH-1]}} : $unsigned($signed(s1_a_q) >>> s1_rot_q);
    ror_v = (s1_rot_q == '0) ? s1_a_q
          : ((s1_a_q >> s1_rot_q) | (s1_a_q << (WIDTH_U - 32'(s1_rot_q))));
    rol_v = (s1_rot_q == '0) ? s1_a_q
          : ((s1_a_q << s1_rot_q) | (s1_a_q >> (WIDTH_U - 32'(s1_rot_q))));
  end

  always_comb begin
    calc_a   = s1_a_q;
    calc_b   = s1_b_q;
    calc_err = 1'b0;
    case (s1_op_q)
      OP_SHR:  calc_a = shr_v;
      OP_SHL:  calc_a = shl_v;
      OP_ROR:  calc_a = ror_v;
      OP_ROL:  calc_a = rol_v;
      OP_ASR:  calc_a = asr_v;
      OP_SWAP: begin
        calc_a = s1_b_q;
        calc_b = s1_a_q;
      end
      default: calc_err = 1'b1;
    endcase
  end

  // S2 holds its contents while the consumer stalls.
  always_comb begin
    s2_valid_d = s2_valid_q;
    res_a_d    = res_a_q;
    res_b_d    = res_b_q;
    err_d      = err_q;
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        res_a_d = calc_a;
        res_b_d = calc_b;
        err_d   = calc_err;
      end
    end
  end

  always_comb begin
    done_cnt_d = done_cnt_q;
    if (s2_valid_q && bus.out_ready && (done_cnt_q != '1))
      done_cnt_d = done_cnt_q + CNT_W'(1);
  end

  // NOTE: datapath registers are reset as well, so outputs and S1 operands are never X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments only.
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_rot_q   <= '0;
      s1_sat_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      res_a_q    <= '0;
      res_b_q    <= '0;
      err_q      <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_rot_q   <= s1_rot_d;
      s1_sat_q   <= s1_sat_d;
      s2_valid_q <= s2_valid_d;
      res_a_q    <= res_a_d;
      res_b_q    <= res_b_d;
      err_q      <= err_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_res_a = res_a_q;
  assign bus.out_res_b = res_b_q;
  assign bus.out_err   = err_q;
  assign done_cnt      = done_cnt_q;

endmodule

// File: tb/tb_shift_rotate_pipe.sv
// Directed bench for shift_rotate_pipe (WIDTH=20, AMT_W=5): reset, ops,
// amount boundaries, backpressure and asynchronous reset with work in flight.
module tb_shift_rotate_pipe;
  localparam int WIDTH = 20;
  localparam int AMT_W = 5;
  localparam int CNT_W = 16;

  localparam logic [2:0] OP_SHR  = 3'b000;
  localparam logic [2:0] OP_SHL  = 3'b001;
  localparam logic [2:0] OP_ROR  = 3'b010;
  localparam logic [2:0] OP_ROL  = 3'b011;
  localparam logic [2:0] OP_ASR  = 3'b100;
  localparam logic [2:0] OP_SWAP = 3'b101;
  localparam logic [2:0] OP_R110 = 3'b110;
  localparam logic [2:0] OP_R111 = 3'b111;

  logic             clk = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] done_cnt;
  int               checks   = 0;
  int               errors   = 0;
  int               exp_done = 0;

  shift_rotate_pipe_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

  shift_rotate_pipe #(.WIDTH(WIDTH), .AMT_W(AMT_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .done_cnt (done_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [19:0] a, input logic [19:0] b,
                       input logic [4:0] amt);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_amt   = amt;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_op    = 3'b000;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_amt   = '0;
  endtask

  // Single op with no backpressure: result visible after the second edge.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [19:0] a,
                        input logic [19:0] b, input logic [4:0] amt,
                        input logic [19:0] exp_a, input logic [19:0] exp_b, input logic exp_err);
    @(negedge clk);
    bus.out_ready = 1'b1;
    drive(op, a, b, amt);
    @(negedge clk);
    idle();
    check({tag, " not_yet_valid"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check({tag, " valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, " res_a"}, 32'(bus.out_res_a), 32'(exp_a));
    check({tag, " res_b"}, 32'(bus.out_res_b), 32'(exp_b));
    check({tag, " err"},   32'(bus.out_err),   32'(exp_err));
    exp_done++;
  endtask

  initial begin
    rst = 1'b1;
    bus.out_ready = 1'b0;
    idle();
    #3;
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst res_a",     32'(bus.out_res_a), 32'd0);
    check("rst res_b",     32'(bus.out_res_b), 32'd0);
    check("rst err",       32'(bus.out_err),   32'd0);
    check("rst done_cnt",  32'(done_cnt),      32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check("post_rst in_ready", 32'(bus.in_ready), 32'd1);

    // Backpressure: three back-to-back requests against a stalled consumer.
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(OP_SHL, 20'h00001, 20'h00000, 5'd1);
    #1 check("bp in_ready first", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    drive(OP_SHL, 20'h00001, 20'h00000, 5'd2);
    #1 check("bp in_ready second", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    drive(OP_SHL, 20'h00001, 20'h00000, 5'd3);
    #1;
    check("bp in_ready full", 32'(bus.in_ready),  32'd0);
    check("bp out_valid",     32'(bus.out_valid), 32'd1);
    check("bp res_a held",    32'(bus.out_res_a), 32'h00002);
    @(negedge clk);
    check("bp in_ready still", 32'(bus.in_ready),  32'd0);
    check("bp res_a stable",   32'(bus.out_res_a), 32'h00002);
    check("bp res_b stable",   32'(bus.out_res_b), 32'h00000);
    @(negedge clk);
    check("bp res_a stable2", 32'(bus.out_res_a), 32'h00002);
    bus.out_ready = 1'b1;
    #1 check("bp in_ready release", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    idle();
    check("bp second valid", 32'(bus.out_valid), 32'd1);
    check("bp second res_a", 32'(bus.out_res_a), 32'h00004);
    @(negedge clk);
    check("bp third valid", 32'(bus.out_valid), 32'd1);
    check("bp third res_a", 32'(bus.out_res_a), 32'h00008);
    @(negedge clk);
    check("bp drained", 32'(bus.out_valid), 32'd0);
    check("bp done_cnt", 32'(done_cnt), 32'd3);
    exp_done = 3;

    run_op("ror1",      OP_ROR,  20'h00001, 20'h00ABC, 5'd1,  20'h80000, 20'h00ABC, 1'b0);
    run_op("rol4",      OP_ROL,  20'h80001, 20'h00000, 5'd4,  20'h00018, 20'h00000, 1'b0);
    run_op("ror21",     OP_ROR,  20'h00001, 20'h00000, 5'd21, 20'h80000, 20'h00000, 1'b0);
    run_op("rol20",     OP_ROL,  20'h12345, 20'h00000, 5'd20, 20'h12345, 20'h00000, 1'b0);
    run_op("ror4",      OP_ROR,  20'h12345, 20'h00000, 5'd4,  20'h51234, 20'h00000, 1'b0);
    run_op("shr25",     OP_SHR,  20'hFFFFF, 20'h00000, 5'd25, 20'h00000, 20'h00000, 1'b0);
    run_op("shl25",     OP_SHL,  20'hFFFFF, 20'h00000, 5'd25, 20'h00000, 20'h00000, 1'b0);
    run_op("shl20",     OP_SHL,  20'h00001, 20'h00000, 5'd20, 20'h00000, 20'h00000, 1'b0);
    run_op("shl19",     OP_SHL,  20'h00003, 20'h00000, 5'd19, 20'h80000, 20'h00000, 1'b0);
    run_op("shr19",     OP_SHR,  20'h80000, 20'h00000, 5'd19, 20'h00001, 20'h00000, 1'b0);
    run_op("shr0",      OP_SHR,  20'hF0000, 20'h00000, 5'd0,  20'hF0000, 20'h00000, 1'b0);
    run_op("asr4",      OP_ASR,  20'h80000, 20'h00000, 5'd4,  20'hF8000, 20'h00000, 1'b0);
    run_op("asr31",     OP_ASR,  20'h80000, 20'h00000, 5'd31, 20'hFFFFF, 20'h00000, 1'b0);
    run_op("asr20",     OP_ASR,  20'h80000, 20'h00000, 5'd20, 20'hFFFFF, 20'h00000, 1'b0);
    run_op("asr_pos",   OP_ASR,  20'h40000, 20'h00000, 5'd2,  20'h10000, 20'h00000, 1'b0);
    run_op("swap",      OP_SWAP, 20'h12345, 20'hABCDE, 5'd7,  20'hABCDE, 20'h12345, 1'b0);
    run_op("swap_same", OP_SWAP, 20'h0F0F0, 20'h0F0F0, 5'd0,  20'h0F0F0, 20'h0F0F0, 1'b0);
    run_op("rsv110",    OP_R110, 20'h12345, 20'h00F0F, 5'd3,  20'h12345, 20'h00F0F, 1'b1);
    run_op("rsv111",    OP_R111, 20'h54321, 20'hA5A5A, 5'd1,  20'h54321, 20'hA5A5A, 1'b1);
    @(negedge clk);
    check("done_cnt total", 32'(done_cnt), 32'(exp_done));

    // Asynchronous reset with two requests in flight.
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(OP_ROR, 20'h00001, 20'h00000, 5'd1);
    @(negedge clk);
    drive(OP_ROL, 20'h00001, 20'h00000, 5'd1);
    @(negedge clk);
    idle();
    check("inflight out_valid", 32'(bus.out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async rst out_valid", 32'(bus.out_valid), 32'd0);
    check("async rst res_a",     32'(bus.out_res_a), 32'd0);
    check("async rst done_cnt",  32'(done_cnt),      32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("post_rst no_result %0d", i), 32'(bus.out_valid), 32'd0);
    end
    check("post_rst done_cnt", 32'(done_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
